// File: rtl/axil_reg_slice_pkg.sv
// AXI4-Lite register-slice shared types: bus widths, per-channel payload structs, response codes, skid FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package axil_pkg;

   // Bus geometry for the whole slice; the interface and every channel struct derive from these.
   localparam int ADDR_WIDTH = 40;
   localparam int DATA_WIDTH = 32;
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [2:0]            prot;
   } aw_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [STRB_WIDTH-1:0] strb;
   } w_t;

   typedef struct packed {
      logic [1:0] resp;
   } b_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [2:0]            prot;
   } ar_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [1:0]            resp;
   } r_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_t;

endpackage

// File: rtl/axil_reg_slice_if.sv
// AXI4-Lite bundle (AW, W, B, AR, R) with master/slave views.
// Latency: n/a (wires only).
// Backpressure: plain valid/ready per channel.
// Ports: aw{valid,ready,addr,prot} w{valid,ready,data,strb} b{valid,ready,resp} ar{valid,ready,addr,prot} r{valid,ready,data,resp}
interface axil_reg_slice_if;
   import axil_pkg::*;

   logic                  awvalid;
   logic                  awready;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [2:0]            awprot;

   logic                  wvalid;
   logic                  wready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;

   logic                  bvalid;
   logic                  bready;
   logic [1:0]            bresp;

   logic                  arvalid;
   logic                  arready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [2:0]            arprot;

   logic                  rvalid;
   logic                  rready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;

   modport master (
      output awvalid, awaddr, awprot, input awready,
      output wvalid, wdata, wstrb, input wready,
      input bvalid, bresp, output bready,
      output arvalid, araddr, arprot, input arready,
      input rvalid, rdata, rresp, output rready
   );

   modport slave (
      input awvalid, awaddr, awprot, output awready,
      input wvalid, wdata, wstrb, output wready,
      output bvalid, bresp, input bready,
      input arvalid, araddr, arprot, output arready,
      output rvalid, rdata, rresp, input rready
   );

endinterface

// File: rtl/axil_reg_slice_skid_buf.sv
// Two-entry skid buffer: every output (in_rdy, out_vld, out_dat) comes straight from a flop.
// Latency: 1 clock from input handshake to out_vld; one beat per clock sustained.
// Backpressure: out_rdy low lets one more beat land in the skid register, then in_rdy drops.
// Ports: axi_aclk/axi_areset; in_{vld,rdy,dat} upstream side; out_{vld,rdy,dat} downstream side.
module skid_buf
   import axil_pkg::*;
#(
   parameter type T = logic
) (
   input  logic axi_aclk,
   input  logic axi_areset,
   input  logic in_vld,
   output logic in_rdy,
   input  T     in_dat,
   output logic out_vld,
   input  logic out_rdy,
   output T     out_dat
);

   skid_state_t state;
   T            main_q;
   T            skid_q;
   logic        push;
   logic        pop;

   assign push    = in_vld & in_rdy;
   assign pop     = out_vld & out_rdy;
   assign out_dat = main_q;

   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         state   <= ST_EMPTY;
         in_rdy  <= 1'b0;
         out_vld <= 1'b0;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         unique case (state)
            ST_EMPTY: begin
               // in_rdy is still low on the first clock after reset; raise it here.
               in_rdy <= 1'b1;
               if (push) begin
                  main_q  <= in_dat;
                  out_vld <= 1'b1;
                  state   <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (push && !pop) begin
                  skid_q <= in_dat;
                  in_rdy <= 1'b0;
                  state  <= ST_FULL;
               end else if (pop && !push) begin
                  out_vld <= 1'b0;
                  state   <= ST_EMPTY;
               end else if (push && pop) begin
                  // Outgoing beat leaves as the new one lands: main simply reloads.
                  main_q <= in_dat;
               end
            end
            ST_FULL: begin
               // in_rdy is low here, so only a pop can occur.
               if (pop) begin
                  main_q <= skid_q;
                  in_rdy <= 1'b1;
                  state  <= ST_ONE;
               end
            end
            default: begin
               state   <= ST_EMPTY;
               in_rdy  <= 1'b0;
               out_vld <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/axil_reg_slice.sv
// AXI4-Lite register slice: one skid buffer per channel between the interconnect and the register file.
// Latency: 1 clock per channel (AW/W/AR forward, B/R backward); full throughput.
// Backpressure: each channel absorbs at most one extra beat after its ready drops, then stalls upstream.
// Ports: axi_aclk, axi_areset (sync, active-high); s_axi = upstream slave view; m_axi = regfile-facing master view.
module axil_reg_slice
   import axil_pkg::*;
(
   input  logic             axi_aclk,
   input  logic             axi_areset,
   axil_reg_slice_if.slave  s_axi,
   axil_reg_slice_if.master m_axi
);

   aw_t aw_in, aw_out;
   w_t  w_in,  w_out;
   b_t  b_in,  b_out;
   ar_t ar_in, ar_out;
   r_t  r_in,  r_out;

   assign aw_in.addr = s_axi.awaddr;
   assign aw_in.prot = s_axi.awprot;
   assign w_in.data  = s_axi.wdata;
   assign w_in.strb  = s_axi.wstrb;
   assign ar_in.addr = s_axi.araddr;
   assign ar_in.prot = s_axi.arprot;
   assign b_in.resp  = m_axi.bresp;
   assign r_in.data  = m_axi.rdata;
   assign r_in.resp  = m_axi.rresp;

   assign m_axi.awaddr = aw_out.addr;
   assign m_axi.awprot = aw_out.prot;
   assign m_axi.wdata  = w_out.data;
   assign m_axi.wstrb  = w_out.strb;
   assign m_axi.araddr = ar_out.addr;
   assign m_axi.arprot = ar_out.prot;
   assign s_axi.bresp  = b_out.resp;
   assign s_axi.rdata  = r_out.data;
   assign s_axi.rresp  = r_out.resp;

   skid_buf #(.T(aw_t)) u_aw (
      .axi_aclk(axi_aclk), .axi_areset(axi_areset),
      .in_vld(s_axi.awvalid), .in_rdy(s_axi.awready), .in_dat(aw_in),
      .out_vld(m_axi.awvalid), .out_rdy(m_axi.awready), .out_dat(aw_out)
   );

   skid_buf #(.T(w_t)) u_w (
      .axi_aclk(axi_aclk), .axi_areset(axi_areset),
      .in_vld(s_axi.wvalid), .in_rdy(s_axi.wready), .in_dat(w_in),
      .out_vld(m_axi.wvalid), .out_rdy(m_axi.wready), .out_dat(w_out)
   );

   skid_buf #(.T(b_t)) u_b (
      .axi_aclk(axi_aclk), .axi_areset(axi_areset),
      .in_vld(m_axi.bvalid), .in_rdy(m_axi.bready), .in_dat(b_in),
      .out_vld(s_axi.bvalid), .out_rdy(s_axi.bready), .out_dat(b_out)
   );

   skid_buf #(.T(ar_t)) u_ar (
      .axi_aclk(axi_aclk), .axi_areset(axi_areset),
      .in_vld(s_axi.arvalid), .in_rdy(s_axi.arready), .in_dat(ar_in),
      .out_vld(m_axi.arvalid), .out_rdy(m_axi.arready), .out_dat(ar_out)
   );

   skid_buf #(.T(r_t)) u_r (
      .axi_aclk(axi_aclk), .axi_areset(axi_areset),
      .in_vld(m_axi.rvalid), .in_rdy(m_axi.rready), .in_dat(r_in),
      .out_vld(s_axi.rvalid), .out_rdy(s_axi.rready), .out_dat(r_out)
   );

endmodule

// File: tb/tb_axil_reg_slice.sv
// Directed bench for axil_reg_slice: reset, AR streaming, AW backpressure, regfile round trip,
// W-before-AW ordering and reset with a full R slice. A small register-file responder sits on m_axi.
module tb_axil_reg_slice;
   import axil_pkg::*;

   logic axi_aclk   = 1'b0;
   logic axi_areset = 1'b1;
   always #5 axi_aclk = ~axi_aclk;

   axil_reg_slice_if s_if();
   axil_reg_slice_if m_if();

   axil_reg_slice dut (
      .axi_aclk  (axi_aclk),
      .axi_areset(axi_areset),
      .s_axi     (s_if),
      .m_axi     (m_if)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Handshakes sampled on the falling edge, i.e. the ones that complete on the next rising edge.
   logic        s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs;
   logic        m_aw_hs, m_w_hs, m_b_hs, m_ar_hs, m_r_hs;
   logic        s_aw_rdy_smp;
   logic [39:0] m_aw_addr_smp, m_ar_addr_smp;
   logic [31:0] m_w_data_smp, s_r_data_smp;
   logic [3:0]  m_w_strb_smp;
   logic [1:0]  s_b_resp_smp, s_r_resp_smp;
   int          s_b_cnt = 0;
   int          s_r_cnt = 0;

   // Register-file model: reg0/reg1 read-only constants, reg2 read-write (drives the LEDs), others SLVERR.
   logic        rf_en   = 1'b0;
   logic [31:0] rf_reg2 = 32'h0;
   logic        aw_pend = 1'b0;
   logic        w_pend  = 1'b0;
   logic [39:0] aw_addr_q;
   logic [31:0] w_data_q;
   logic [3:0]  w_strb_q;
   logic [3:0]  led;
   assign led = rf_reg2[3:0];

   task automatic tick();
      @(negedge axi_aclk);
      s_aw_hs = s_if.awvalid & s_if.awready;
      s_w_hs  = s_if.wvalid  & s_if.wready;
      s_b_hs  = s_if.bvalid  & s_if.bready;
      s_ar_hs = s_if.arvalid & s_if.arready;
      s_r_hs  = s_if.rvalid  & s_if.rready;
      m_aw_hs = m_if.awvalid & m_if.awready;
      m_w_hs  = m_if.wvalid  & m_if.wready;
      m_b_hs  = m_if.bvalid  & m_if.bready;
      m_ar_hs = m_if.arvalid & m_if.arready;
      m_r_hs  = m_if.rvalid  & m_if.rready;
      s_aw_rdy_smp  = s_if.awready;
      m_aw_addr_smp = m_if.awaddr;
      m_ar_addr_smp = m_if.araddr;
      m_w_data_smp  = m_if.wdata;
      m_w_strb_smp  = m_if.wstrb;
      s_b_resp_smp  = s_if.bresp;
      s_r_data_smp  = s_if.rdata;
      s_r_resp_smp  = s_if.rresp;
      @(posedge axi_aclk);
      #1;
      if (s_b_hs) s_b_cnt++;
      if (s_r_hs) s_r_cnt++;
      if (rf_en) begin
         if (axi_areset) begin
            m_if.bvalid = 1'b0;
            m_if.rvalid = 1'b0;
            aw_pend     = 1'b0;
            w_pend      = 1'b0;
         end else begin
            if (m_aw_hs) begin aw_pend = 1'b1; aw_addr_q = m_aw_addr_smp; end
            if (m_w_hs)  begin w_pend = 1'b1; w_data_q = m_w_data_smp; w_strb_q = m_w_strb_smp; end
            if (m_b_hs) m_if.bvalid = 1'b0;
            if (aw_pend && w_pend && !m_if.bvalid) begin
               if (aw_addr_q[3:2] == 2'd2) begin
                  for (int b = 0; b < 4; b++)
                     if (w_strb_q[b]) rf_reg2[8*b +: 8] = w_data_q[8*b +: 8];
                  m_if.bresp = RESP_OKAY;
               end else begin
                  m_if.bresp = RESP_SLVERR;
               end
               m_if.bvalid = 1'b1;
               aw_pend     = 1'b0;
               w_pend      = 1'b0;
            end
            if (m_r_hs) m_if.rvalid = 1'b0;
            if (m_ar_hs) begin
               m_if.rvalid = 1'b1;
               case (m_ar_addr_smp[3:2])
                  2'd0:    begin m_if.rdata = 32'hDEADBEEF; m_if.rresp = RESP_OKAY;   end
                  2'd1:    begin m_if.rdata = 32'h76543210; m_if.rresp = RESP_OKAY;   end
                  2'd2:    begin m_if.rdata = rf_reg2;      m_if.rresp = RESP_OKAY;   end
                  default: begin m_if.rdata = 32'h0;        m_if.rresp = RESP_SLVERR; end
               endcase
            end
         end
      end
   endtask

   task automatic axi_write(input logic [39:0] a, input logic [31:0] d, input int w_lead,
                            output logic [1:0] resp);
      bit got = 1'b0;
      resp = 2'bxx;
      s_if.wvalid = 1'b1; s_if.wdata = d; s_if.wstrb = 4'hF;
      s_if.awaddr = a; s_if.awprot = 3'd0;
      s_if.bready = 1'b1;
      for (int c = 0; c < 60 && !got; c++) begin
         if (c == w_lead) s_if.awvalid = 1'b1;
         tick();
         if (s_aw_hs) s_if.awvalid = 1'b0;
         if (s_w_hs) begin
            s_if.wvalid = 1'b0;
            if (w_lead > 0) begin
               chk("w_fwd_vld", m_if.wvalid, 1);
               chk("w_fwd_dat", m_if.wdata, d);
               chk("w_fwd_no_aw", m_if.awvalid, 0);
            end
         end
         if (s_b_hs) begin got = 1'b1; resp = s_b_resp_smp; end
      end
      chk("wr_done", got, 1);
      s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
   endtask

   task automatic axi_read(input logic [39:0] a, output logic [31:0] d, output logic [1:0] resp);
      bit got = 1'b0;
      d = 'x; resp = 'x;
      s_if.arvalid = 1'b1; s_if.araddr = a; s_if.arprot = 3'd0;
      s_if.rready  = 1'b1;
      for (int c = 0; c < 60 && !got; c++) begin
         tick();
         if (s_ar_hs) s_if.arvalid = 1'b0;
         if (s_r_hs) begin got = 1'b1; d = s_r_data_smp; resp = s_r_resp_smp; end
      end
      chk("rd_done", got, 1);
      s_if.arvalid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1);
   end

   initial begin
      logic [39:0] aw_q[$];
      logic [31:0] rd;
      logic [1:0]  rs;
      int          idx, stall_push, b0, r0;
      bit          ok;

      s_if.awvalid = 1'b1; s_if.awaddr = 40'h0; s_if.awprot = 3'd0;
      s_if.wvalid = 1'b0; s_if.wdata = 32'h0; s_if.wstrb = 4'h0; s_if.bready = 1'b0;
      s_if.arvalid = 1'b0; s_if.araddr = 40'h0; s_if.arprot = 3'd0; s_if.rready = 1'b0;
      m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.bvalid = 1'b0; m_if.bresp = 2'b00;
      m_if.arready = 1'b0; m_if.rvalid = 1'b0; m_if.rdata = 32'h0; m_if.rresp = 2'b00;

      // 1. Reset held 4 clocks with AWVALID asserted: every valid and ready must stay low.
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rst_hs_lines", {s_if.awready, s_if.wready, s_if.arready, s_if.bvalid, s_if.rvalid,
                              m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready}, 0);
      end
      chk("rst_payload", m_if.awaddr, 0);
      axi_areset = 1'b0;
      tick();
      chk("rel_awready", s_if.awready, 1);
      chk("rel_arready", s_if.arready, 1);
      chk("rel_no_aw", m_if.awvalid, 0);
      s_if.awvalid = 1'b0;

      // 2. Sixteen back-to-back AR beats with the regfile always ready.
      m_if.arready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         s_if.arvalid = 1'b1;
         s_if.araddr  = 40'(4 * i);
         tick();
         chk("st_ar_hs", s_ar_hs, 1);
         chk("st_m_vld", m_if.arvalid, 1);
         chk("st_m_addr", m_if.araddr, 40'(4 * i));
      end
      s_if.arvalid = 1'b0;
      tick();
      chk("st_drain", m_if.arvalid, 0);
      m_if.arready = 1'b0;

      // 3. AW stream of 10 beats; downstream ready low for cycles 5..9.
      idx = 0; stall_push = 0;
      for (int c = 0; c < 25; c++) begin
         m_if.awready = !(c >= 5 && c <= 9);
         s_if.awvalid = (idx < 10);
         s_if.awaddr  = 40'h100 + 40'(4 * idx);
         tick();
         if (c == 5) chk("bp_rdy_before", s_aw_rdy_smp, 1);
         if (c == 6) chk("bp_rdy_drop", s_aw_rdy_smp, 0);
         if (s_aw_hs) begin
            idx++;
            if (c >= 5 && c <= 9) stall_push++;
         end
         if (m_aw_hs) aw_q.push_back(m_aw_addr_smp);
         if (c >= 5 && c <= 9) begin
            chk("bp_hold_vld", m_if.awvalid, 1);
            chk("bp_hold_addr", m_if.awaddr, 40'h110);
         end
      end
      s_if.awvalid = 1'b0;
      chk("bp_extra_beats", stall_push, 1);
      chk("bp_out_count", aw_q.size(), 10);
      for (int i = 0; i < aw_q.size(); i++)
         chk("bp_out_order", aw_q[i], 40'h100 + 40'(4 * i));

      // 4. Regfile round trip.
      rf_en = 1'b1;
      m_if.awready = 1'b1; m_if.wready = 1'b1; m_if.arready = 1'b1;
      axi_write(40'h08, 32'h0000_0003, 0, rs);
      chk("rt_bresp", rs, RESP_OKAY);
      chk("rt_led", led, 4'h3);
      axi_read(40'h00, rd, rs); chk("rt_rd0", rd, 32'hDEADBEEF); chk("rt_rresp0", rs, RESP_OKAY);
      axi_read(40'h04, rd, rs); chk("rt_rd1", rd, 32'h76543210); chk("rt_rresp1", rs, RESP_OKAY);
      axi_read(40'h08, rd, rs); chk("rt_rd2", rd, 32'h00000003); chk("rt_rresp2", rs, RESP_OKAY);
      axi_read(40'h0C, rd, rs); chk("rt_slverr", rs, RESP_SLVERR);

      // 5. W presented three clocks ahead of AW.
      b0 = s_b_cnt;
      axi_write(40'h08, 32'h0000_00A5, 3, rs);
      chk("ord_bresp", rs, RESP_OKAY);
      for (int i = 0; i < 4; i++) tick();
      chk("ord_b_once", s_b_cnt - b0, 1);
      chk("ord_led", led, 4'h5);
      axi_read(40'h08, rd, rs); chk("ord_rd2", rd, 32'h0000_00A5);

      // 6. Fill the R slice (upstream not ready), then reset.
      s_if.rready = 1'b0;
      s_if.arvalid = 1'b1; s_if.araddr = 40'h00;
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin tick(); ok = s_ar_hs; end
      s_if.araddr = 40'h04;
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin tick(); ok = s_ar_hs; end
      s_if.arvalid = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("rf_full_rdy", m_if.rready, 0);
      chk("rf_full_vld", s_if.rvalid, 1);
      chk("rf_full_dat", s_if.rdata, 32'hDEADBEEF);
      axi_areset = 1'b1;
      tick(); tick();
      chk("rf_rst_vld", s_if.rvalid, 0);
      chk("rf_rst_dat", s_if.rdata, 0);
      axi_areset = 1'b0;
      r0 = s_r_cnt;
      s_if.rready = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("rf_no_stale", s_r_cnt - r0, 0);
      axi_read(40'h04, rd, rs);
      chk("rf_fresh_dat", rd, 32'h76543210);
      chk("rf_fresh_resp", rs, RESP_OKAY);
      chk("rf_fresh_once", s_r_cnt - r0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
